matrix_stream_loader: RTL and testbench

MATRIX_STREAM_LOADER -- requirements
Module: matrix_stream_loader

---
 rtl/matrix_stream_loader.sv | 116 +++++++++++
 tb/tb_matrix_stream_loader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/matrix_stream_loader.sv
// Assembles a WIDTH x WIDTH matrix of 32-bit elements from a valid/ready stream and
// issues a single data-memory write strobe. Optional MATRIX_TRANSPOSE_EN selects column-major placement.
`ifndef WIDTH_BIT
`define WIDTH_BIT 2
`endif
`ifndef INDEX_BIT
`define INDEX_BIT 4
`endif

module matrix_stream_loader #(
    parameter int WIDTH     = 2 ** `WIDTH_BIT,
    parameter int INDEX_BIT = `INDEX_BIT
) (
    input  logic                                   CLK,
    input  logic                                   RST,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [31:0]                            in_data,
    input  logic [INDEX_BIT-1:0]                   in_index,
    input  logic                                   abort,
    output logic                                   write_enable,
    output logic [INDEX_BIT-1:0]                   write,
    output logic [0:WIDTH-1][0:WIDTH-1][31:0]      write_data,
    output logic                                   busy
);

    localparam int CNT_W = 2 * `WIDTH_BIT + 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH * WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] row_idx;
    logic [IDX_W-1:0] col_idx;

    always_comb begin
        logic [31:0] k;
        k = 32'(cnt);
`ifdef MATRIX_TRANSPOSE_EN
        row_idx = IDX_W'(k % 32'(WIDTH));
        col_idx = IDX_W'(k / 32'(WIDTH));
`else
        row_idx = IDX_W'(k / 32'(WIDTH));
        col_idx = IDX_W'(k % 32'(WIDTH));
`endif
    end

    // busy/in_ready are registered alongside the state so they track it exactly.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            cnt          <= '0;
            write_enable <= 1'b0;
            write        <= '0;
            write_data   <= '0;
            busy         <= 1'b0;
            in_ready     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (abort) begin
                        cnt <= '0;
                    end else if (in_valid) begin
                        write_data[0][0] <= in_data;
                        write            <= in_index;
                        cnt              <= CNT_W'(1);
                        busy             <= 1'b1;
                        if (WIDTH * WIDTH == 1) begin
                            state        <= WRITE;
                            write_enable <= 1'b1;
                            in_ready     <= 1'b0;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (abort) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (in_valid) begin
                        write_data[row_idx][col_idx] <= in_data;
                        cnt                          <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state        <= WRITE;
                            write_enable <= 1'b1;
                            in_ready     <= 1'b0;
                        end
                    end
                end
                WRITE: begin
                    state        <= IDLE;
                    cnt          <= '0;
                    write_enable <= 1'b0;
                    in_ready     <= 1'b1;
                    busy         <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    cnt          <= '0;
                    write_enable <= 1'b0;
                    in_ready     <= 1'b1;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Self-checking bench for matrix_stream_loader (WIDTH=4, INDEX_BIT=4) against a
// transaction-level model built from queued elements.
module tb_matrix_stream_loader;

    logic                          CLK = 1'b0;
    logic                          RST = 1'b0;
    logic                          in_valid = 1'b0;
    logic                          in_ready;
    logic [31:0]                   in_data = '0;
    logic [3:0]                    in_index = '0;
    logic                          abort = 1'b0;
    logic                          write_enable;
    logic [3:0]                    write;
    logic [0:3][0:3][31:0]         write_data;
    logic                          busy;

    matrix_stream_loader #(.WIDTH(4), .INDEX_BIT(4)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_index     (in_index),
        .abort        (abort),
        .write_enable (write_enable),
        .write        (write),
        .write_data   (write_data),
        .busy         (busy)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int n_we    = 0;

    // Reference model: elements accepted so far, last latched index, expected matrix.
    int unsigned            m_elems[$];
    logic [3:0]             m_write = '0;
    logic                   m_pending = 1'b0;
    logic                   m_hold = 1'b1;
    logic [0:3][0:3][31:0]  m_data = '0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_elems.delete();
        m_write   = '0;
        m_pending = 1'b0;
        m_hold    = 1'b1;
        m_data    = '0;
    endtask

    task automatic model_edge();
        logic [1:0] r, c;
        if (m_pending) begin
            m_pending = 1'b0;
        end else if (abort) begin
            m_elems.delete();
        end else if (in_valid) begin
            if (m_elems.size() == 0) begin
                m_write = in_index;
                m_hold  = 1'b0;
            end
            m_elems.push_back(in_data);
            if (m_elems.size() == 16) begin
                for (int k = 0; k < 16; k++) begin
`ifdef MATRIX_TRANSPOSE_EN
                    r = 2'(k % 4);
                    c = 2'(k / 4);
`else
                    r = 2'(k / 4);
                    c = 2'(k % 4);
`endif
                    m_data[r][c] = m_elems[k];
                end
                m_elems.delete();
                m_pending = 1'b1;
                m_hold    = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        if (write_enable) n_we++;
        check("write_enable", 512'(write_enable), 512'(m_pending));
        check("in_ready", 512'(in_ready), 512'(!m_pending));
        check("busy", 512'(busy), 512'(m_pending || m_elems.size() > 0));
        check("write", 512'(write), 512'(m_write));
        if (m_hold) check("write_data", 512'(write_data), 512'(m_data));
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic [3:0] idx, input logic ab);
        in_valid = v;
        in_data  = d;
        in_index = idx;
        abort    = ab;
        @(posedge CLK);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic stream(input logic [3:0] idx, input int unsigned base, input int unsigned n, input logic gaps);
        for (int unsigned i = 0; i < n; i++) begin
            if (gaps) begin
                int unsigned g;
                g = $urandom_range(0, 3);
                for (int unsigned j = 0; j < g; j++) step(1'b0, $urandom, idx, 1'b0);
            end
            step(1'b1, base + i, idx, 1'b0);
        end
    endtask

    initial begin
        model_reset();
        #12;
        check("reset_we", 512'(write_enable), 512'(0));
        check("reset_busy", 512'(busy), 512'(0));
        check("reset_write", 512'(write), 512'(0));
        check("reset_data", 512'(write_data), 512'(0));
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("reset_in_ready", 512'(in_ready), 512'(1));

        // Back-to-back matrix, index 5, elements 1..16
        n_we = 0;
        stream(4'd5, 1, 16, 1'b0);
        check("b2b_we", 512'(write_enable), 512'(1));
        check("b2b_in_ready", 512'(in_ready), 512'(0));
        check("b2b_write", 512'(write), 512'(5));
`ifdef MATRIX_TRANSPOSE_EN
        check("tr_10", 512'(write_data[1][0]), 512'(2));
        check("tr_01", 512'(write_data[0][1]), 512'(5));
`else
        check("rm_01", 512'(write_data[0][1]), 512'(2));
        check("rm_10", 512'(write_data[1][0]), 512'(5));
`endif
        check("b2b_33", 512'(write_data[3][3]), 512'(16));
        step(1'b0, '0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b0);
        check("b2b_we_count", 512'(n_we), 512'(1));

        // Same stream with random gaps
        n_we = 0;
        stream(4'd5, 1, 16, 1'b1);
        step(1'b0, '0, '0, 1'b0);
        check("gap_we_count", 512'(n_we), 512'(1));

        // Partial matrix aborted, then a full one
        n_we = 0;
        stream(4'd9, 50, 7, 1'b0);
        step(1'b1, 32'd999, 4'd9, 1'b1);
        stream(4'd2, 100, 16, 1'b0);
        check("abort_write", 512'(write), 512'(2));
        check("abort_00", 512'(write_data[0][0]), 512'(100));
        check("abort_33", 512'(write_data[3][3]), 512'(115));
        step(1'b0, '0, '0, 1'b0);
        check("abort_we_count", 512'(n_we), 512'(1));

        // in_valid held with 200 across the WRITE cycle
        stream(4'd3, 300, 16, 1'b0);
        step(1'b1, 32'd200, 4'd7, 1'b0);
        step(1'b1, 32'd200, 4'd7, 1'b0);
        stream(4'd7, 201, 15, 1'b0);
        check("hold_00", 512'(write_data[0][0]), 512'(200));
        check("hold_write", 512'(write), 512'(7));
        step(1'b0, '0, '0, 1'b0);

        // Asynchronous reset after 10 elements
        n_we = 0;
        stream(4'd11, 400, 10, 1'b0);
        #2;
        RST = 1'b0;
        #1;
        model_reset();
        check("rst_we", 512'(write_enable), 512'(0));
        check("rst_busy", 512'(busy), 512'(0));
        check("rst_write", 512'(write), 512'(0));
        check("rst_data", 512'(write_data), 512'(0));
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("rst_in_ready", 512'(in_ready), 512'(1));
        stream(4'd6, 500, 16, 1'b0);
        check("rst_fresh_write", 512'(write), 512'(6));
        step(1'b0, '0, '0, 1'b0);
        check("rst_we_count", 512'(n_we), 512'(1));

        // Randomized traffic with gaps and occasional aborts
        for (int i = 0; i < 1500; i++) begin
            step(($urandom % 4) != 0, $urandom, 4'($urandom), ($urandom % 60) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
